sync_frame_tx: RTL and testbench

Serial frame transmitter for the 8-bit sync-word link. Each accepted parallel word goes out on a single-bit line, MSB first, as a frame:
- the fixed sync word 1101 0011 (8'hD3),
- then DW payload bits,
- then GAP idle zeros.

It drives the serial input of the link's sync-word detector. It is the transmit end of that link.

---
 rtl/sync_frame_tx.sv | 139 +++++++++++++
 tb/tb_sync_frame_tx.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/sync_frame_tx.sv
// Serial frame transmitter: sync word, MSB-first payload, idle gap.
// Feeds the serial input of the sync-word detector on the same clock.
module sync_frame_tx #(
  parameter logic [7:0] SYNC = 8'hD3,
  parameter int         DW   = 8,
  parameter int         GAP  = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [DW-1:0] data,
  output logic          ready,
  output logic          dout,
  output logic          active,
  output logic          done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SYNC,
    S_DATA,
    S_GAP
  } state_t;

  localparam logic [4:0] CNT_SYNC = 5'd7;
  localparam logic [4:0] CNT_DW   = 5'(DW - 1);
  localparam logic [4:0] CNT_GAP  = 5'((GAP > 0) ? GAP - 1 : 0);

  state_t        state;
  state_t        nstate;
  logic [4:0]    cnt;
  logic [4:0]    ncnt;
  logic [DW-1:0] sh;
  logic [DW-1:0] nsh;
  logic          last;
  logic          take;
  logic          eof;
  logic          ndout;
  logic          nactive;
  logic          ndone;

  assign last = (cnt == 5'd0);
  assign take = load & ready;

  // ready depends only on state and counter: idle or final bit of a frame
  always_comb begin
    ready = 1'b0;
    unique case (state)
      S_IDLE:  ready = 1'b1;
      S_DATA:  ready = last && (GAP == 0);
      S_GAP:   ready = last;
      default: ready = 1'b0;
    endcase
  end

  // next state, counter and payload register
  always_comb begin
    nstate = state;
    ncnt   = cnt;
    nsh    = sh;
    eof    = 1'b0;
    unique case (state)
      S_IDLE: eof = 1'b1;
      S_SYNC: begin
        if (last) begin
          nstate = S_DATA;
          ncnt   = CNT_DW;
        end else begin
          ncnt = cnt - 5'd1;
        end
      end
      S_DATA: begin
        if (!last) begin
          nsh  = sh << 1;
          ncnt = cnt - 5'd1;
        end else if (GAP > 0) begin
          nstate = S_GAP;
          ncnt   = CNT_GAP;
        end else begin
          eof = 1'b1;
        end
      end
      S_GAP: begin
        if (last) eof = 1'b1;
        else      ncnt = cnt - 5'd1;
      end
      default: nstate = S_IDLE;
    endcase
    if (eof) begin
      if (take) begin
        nstate = S_SYNC;
        ncnt   = CNT_SYNC;
        nsh    = data;
      end else begin
        nstate = S_IDLE;
        ncnt   = 5'd0;
      end
    end
  end

  // output values for the bit that the next state will carry
  always_comb begin
    ndout   = 1'b0;
    nactive = 1'b0;
    ndone   = 1'b0;
    unique case (nstate)
      S_SYNC: begin
        ndout   = SYNC[ncnt[2:0]];
        nactive = 1'b1;
      end
      S_DATA: begin
        ndout   = nsh[DW-1];
        nactive = 1'b1;
        ndone   = (ncnt == 5'd0);
      end
      default: ndout = 1'b0;
    endcase
  end

  // single registered FSM with registered serial outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= 5'd0;
      sh     <= '0;
      dout   <= 1'b0;
      active <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= nstate;
      cnt    <= ncnt;
      sh     <= nsh;
      dout   <= ndout;
      active <= nactive;
      done   <= ndone;
    end
  end

endmodule

// File: tb/tb_sync_frame_tx.sv
// Scoreboard bench: three configurations of sync_frame_tx
// checked cycle by cycle against a queue-based frame model.
module tb_sync_frame_tx;

  localparam logic [7:0] SW = 8'hD3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load [3];
  logic [31:0] dat [3];
  logic        dout [3];
  logic        active [3];
  logic        done [3];
  logic        ready [3];

  int checks = 0;
  int failures = 0;

  logic [2:0]  q [3][$];
  logic [7:0]  det = '0;
  int          hits = 0;
  int          hbase = 0;
  int          hwant = 0;
  int          hreq = 0;
  int          hdone = 0;

  always #5 clk = ~clk;

  sync_frame_tx #(.SYNC(8'hD3), .DW(8), .GAP(1)) u0 (
    .clk(clk), .rst_n(rst_n), .load(load[0]), .data(dat[0][7:0]),
    .ready(ready[0]), .dout(dout[0]), .active(active[0]), .done(done[0])
  );

  sync_frame_tx #(.SYNC(8'hD3), .DW(8), .GAP(0)) u1 (
    .clk(clk), .rst_n(rst_n), .load(load[1]), .data(dat[1][7:0]),
    .ready(ready[1]), .dout(dout[1]), .active(active[1]), .done(done[1])
  );

  sync_frame_tx #(.SYNC(8'hD3), .DW(4), .GAP(3)) u2 (
    .clk(clk), .rst_n(rst_n), .load(load[2]), .data(dat[2][3:0]),
    .ready(ready[2]), .dout(dout[2]), .active(active[2]), .done(done[2])
  );

  function automatic int dw_of(int i);
    return (i == 2) ? 4 : 8;
  endfunction

  function automatic int gap_of(int i);
    return (i == 0) ? 1 : (i == 1) ? 0 : 3;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h want=%0h", nm, $time, act, exp);
    end
  endtask

  // expected per-cycle {dout, active, done} for one whole frame
  task automatic push_frame(int i, logic [31:0] w);
    int dw;
    int gp;
    dw = dw_of(i);
    gp = gap_of(i);
    for (int j = 0; j < 8; j++) q[i].push_back({SW[7-j], 1'b1, 1'b0});
    for (int j = 0; j < dw; j++)
      q[i].push_back({w[dw-1-j], 1'b1, (j == dw - 1)});
    for (int j = 0; j < gp; j++) q[i].push_back(3'b000);
  endtask

  // monitor: compare, retire the shown bit, accept new frames
  always begin
    @(negedge clk or negedge rst_n);
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) q[i].delete();
      #1;
      for (int i = 0; i < 3; i++)
        chk($sformatf("reset_u%0d", i),
            {28'd0, dout[i], active[i], done[i], ready[i]}, 32'b0001);
    end else begin
      det = {det[6:0], dout[0]};
      if (det == SW) hits++;
      for (int i = 0; i < 3; i++) begin
        logic [2:0] e;
        logic       er;
        e  = (q[i].size() > 0) ? q[i][0] : 3'b000;
        er = (q[i].size() <= 1);
        chk($sformatf("cycle_u%0d", i),
            {28'd0, dout[i], active[i], done[i], ready[i]},
            {28'd0, e, er});
        if (q[i].size() > 0) void'(q[i].pop_front());
        if (load[i] && q[i].size() == 0) push_frame(i, dat[i]);
      end
      if (hreq != hdone) begin
        chk("det_hits", 32'(hits - hbase), 32'(hwant));
        hdone = hreq;
      end
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send(int i, logic [31:0] w);
    load[i] = 1'b1;
    dat[i]  = w;
    tick(1);
    load[i] = 1'b0;
    dat[i]  = $urandom;
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      load[i] = 1'b0;
      dat[i]  = '0;
    end
    tick(3);
    rst_n = 1'b1;
    tick(3);

    hbase = hits;
    send(0, 32'hA5);
    tick(25);
    hwant = 1;
    hreq++;
    tick(2);

    load[1] = 1'b1;
    dat[1]  = 32'h0F;
    tick(1);
    dat[1] = 32'hF0;
    tick(16);
    load[1] = 1'b0;
    dat[1]  = $urandom;
    tick(20);

    send(0, 32'h00);
    tick(2);
    load[0] = 1'b1;
    dat[0]  = 32'hFF;
    tick(1);
    load[0] = 1'b0;
    tick(6);
    load[0] = 1'b1;
    dat[0]  = 32'hFF;
    tick(1);
    load[0] = 1'b0;
    tick(20);

    send(0, $urandom);
    tick(12);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    send(0, 32'h3C);
    tick(20);

    hbase = hits;
    send(0, 32'hD3);
    tick(22);
    hwant = 2;
    hreq++;
    tick(2);

    send(2, 32'h9);
    tick(18);

    repeat (800) begin
      for (int i = 0; i < 3; i++) begin
        load[i] = ($urandom_range(0, 2) != 0);
        dat[i]  = $urandom;
      end
      tick(1);
    end
    for (int i = 0; i < 3; i++) load[i] = 1'b0;
    tick(60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
